// File: rtl/jtkcpu_irq.sv
// Interrupt front-end for JTKCPU: pin synchronisers, NMI edge detect,
// CC masking, NMI > FIRQ > IRQ priority, vector selection and SYNC/CWAI wake.
module jtkcpu_irq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        nmi_n,
    input  logic        firq_n,
    input  logic        irq_n,
    input  logic        cc_f,
    input  logic        cc_i,
    input  logic        nmi_arm,
    input  logic        ack,
    output logic        int_req,
    output logic [1:0]  int_sel,
    output logic [15:0] vector,
    output logic        fast,
    output logic        wake
);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_IRQ  = 2'd1;
    localparam logic [1:0] SEL_FIRQ = 2'd2;
    localparam logic [1:0] SEL_NMI  = 2'd3;

    logic        nmi_s1_q, nmi_s2_q, nmi_prev_q;
    logic        firq_s1_q, firq_s2_q;
    logic        irq_s1_q, irq_s2_q;
    logic        nmi_armed_q, nmi_armed_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        int_req_q, int_req_d;
    logic [1:0]  int_sel_q, int_sel_d;
    logic [15:0] vector_q, vector_d;
    logic        fast_q, fast_d;
    logic        wake_q, wake_d;

    logic        nmi_edge, firq_act, irq_act, ack_ok;
    logic [1:0]  sel_next;

    always_comb begin
        nmi_edge = ~nmi_s2_q & nmi_prev_q;
        firq_act = ~firq_s2_q & ~cc_f;
        irq_act  = ~irq_s2_q & ~cc_i;
        ack_ok   = ack & int_req_q;

        nmi_armed_d = nmi_armed_q | nmi_arm;

        // A new edge outranks the clear from acknowledging the previous NMI
        nmi_pend_d = nmi_pend_q;
        if (ack_ok && int_sel_q == SEL_NMI) nmi_pend_d = 1'b0;
        if (nmi_edge && nmi_armed_q) nmi_pend_d = 1'b1;

        if (nmi_pend_q)    sel_next = SEL_NMI;
        else if (firq_act) sel_next = SEL_FIRQ;
        else if (irq_act)  sel_next = SEL_IRQ;
        else               sel_next = SEL_NONE;

        case (sel_next)
            SEL_NMI:  vector_d = 16'hFFFC;
            SEL_FIRQ: vector_d = 16'hFFF6;
            SEL_IRQ:  vector_d = 16'hFFF8;
            default:  vector_d = 16'hFFFE;
        endcase

        int_sel_d = sel_next;
        int_req_d = (sel_next != SEL_NONE);
        fast_d    = (sel_next == SEL_FIRQ);

        // Vector is held through the ack gap for the control unit
        if (ack_ok) begin
            int_sel_d = SEL_NONE;
            int_req_d = 1'b0;
            fast_d    = 1'b0;
            vector_d  = vector_q;
        end

        wake_d = nmi_pend_q | ~firq_s2_q | ~irq_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_s1_q    <= 1'b1;
            nmi_s2_q    <= 1'b1;
            nmi_prev_q  <= 1'b1;
            firq_s1_q   <= 1'b1;
            firq_s2_q   <= 1'b1;
            irq_s1_q    <= 1'b1;
            irq_s2_q    <= 1'b1;
            nmi_armed_q <= 1'b0;
            nmi_pend_q  <= 1'b0;
            int_req_q   <= 1'b0;
            int_sel_q   <= SEL_NONE;
            vector_q    <= 16'hFFFE;
            fast_q      <= 1'b0;
            wake_q      <= 1'b0;
        end else if (cen) begin
            nmi_s1_q    <= nmi_n;
            nmi_s2_q    <= nmi_s1_q;
            nmi_prev_q  <= nmi_s2_q;
            firq_s1_q   <= firq_n;
            firq_s2_q   <= firq_s1_q;
            irq_s1_q    <= irq_n;
            irq_s2_q    <= irq_s1_q;
            nmi_armed_q <= nmi_armed_d;
            nmi_pend_q  <= nmi_pend_d;
            int_req_q   <= int_req_d;
            int_sel_q   <= int_sel_d;
            vector_q    <= vector_d;
            fast_q      <= fast_d;
            wake_q      <= wake_d;
        end
    end

    assign int_req = int_req_q;
    assign int_sel = int_sel_q;
    assign vector  = vector_q;
    assign fast    = fast_q;
    assign wake    = wake_q;

endmodule

// File: tb/tb_jtkcpu_irq.sv
// Directed self-checking bench for jtkcpu_irq; inputs change 1 ns after
// each rising edge and outputs are sampled at the same point.
module tb_jtkcpu_irq;

    logic        rst, clk, cen;
    logic        nmi_n, firq_n, irq_n;
    logic        cc_f, cc_i, nmi_arm, ack;
    logic        int_req;
    logic [1:0]  int_sel;
    logic [15:0] vector;
    logic        fast, wake;

    int checks = 0;
    int errors = 0;

    jtkcpu_irq dut (
        .rst     (rst),
        .clk     (clk),
        .cen     (cen),
        .nmi_n   (nmi_n),
        .firq_n  (firq_n),
        .irq_n   (irq_n),
        .cc_f    (cc_f),
        .cc_i    (cc_i),
        .nmi_arm (nmi_arm),
        .ack     (ack),
        .int_req (int_req),
        .int_sel (int_sel),
        .vector  (vector),
        .fast    (fast),
        .wake    (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1;
        nmi_n = 1'b1; firq_n = 1'b1; irq_n = 1'b1;
        cc_f = 1'b0; cc_i = 1'b0; nmi_arm = 1'b0; ack = 1'b0;
        tick(2);
        check("rst_req", 16'(int_req), 16'd0);
        check("rst_sel", 16'(int_sel), 16'd0);
        check("rst_vec", vector, 16'hFFFE);
        check("rst_fast", 16'(fast), 16'd0);
        check("rst_wake", 16'(wake), 16'd0);
        rst = 1'b0;
        tick(3);
        check("idle_req", 16'(int_req), 16'd0);

        // NMI edge while unarmed is discarded
        nmi_n = 1'b0;
        tick(4);
        nmi_n = 1'b1;
        tick(4);
        check("unarmed_req", 16'(int_req), 16'd0);
        check("unarmed_wake", 16'(wake), 16'd0);

        // Arm, then NMI lands on the 4th edge
        nmi_arm = 1'b1;
        tick(1);
        nmi_arm = 1'b0;
        nmi_n = 1'b0;
        tick(3);
        check("nmi_lat3_req", 16'(int_req), 16'd0);
        tick(1);
        check("nmi_req", 16'(int_req), 16'd1);
        check("nmi_sel", 16'(int_sel), 16'd3);
        check("nmi_vec", vector, 16'hFFFC);
        check("nmi_fast", 16'(fast), 16'd0);
        check("nmi_wake", 16'(wake), 16'd1);

        pulse_ack();
        check("nmi_ack_req", 16'(int_req), 16'd0);
        check("nmi_ack_sel", 16'(int_sel), 16'd0);
        check("nmi_ack_vec", vector, 16'hFFFC);

        // Held-low NMI must not retrigger
        tick(20);
        check("held_nmi_req", 16'(int_req), 16'd0);
        check("held_nmi_wake", 16'(wake), 16'd0);
        nmi_n = 1'b1;
        tick(3);

        // FIRQ beats IRQ
        irq_n = 1'b0; firq_n = 1'b0;
        tick(2);
        check("firq_lat2_req", 16'(int_req), 16'd0);
        tick(1);
        check("firq_req", 16'(int_req), 16'd1);
        check("firq_sel", 16'(int_sel), 16'd2);
        check("firq_vec", vector, 16'hFFF6);
        check("firq_fast", 16'(fast), 16'd1);
        pulse_ack();
        check("firq_ack_req", 16'(int_req), 16'd0);
        check("firq_ack_vec", vector, 16'hFFF6);
        tick(1);
        check("firq_again_req", 16'(int_req), 16'd1);
        check("firq_again_sel", 16'(int_sel), 16'd2);
        firq_n = 1'b1;
        tick(3);
        check("irq_sel", 16'(int_sel), 16'd1);
        check("irq_vec", vector, 16'hFFF8);
        check("irq_fast", 16'(fast), 16'd0);

        // Masking drops the request next edge, wake ignores masks
        cc_i = 1'b1;
        tick(1);
        check("mask_req", 16'(int_req), 16'd0);
        check("mask_wake", 16'(wake), 16'd1);
        cc_i = 1'b0;
        tick(1);
        check("unmask_req", 16'(int_req), 16'd1);
        check("unmask_sel", 16'(int_sel), 16'd1);

        // cen low freezes everything
        cen = 1'b0;
        irq_n = 1'b1;
        tick(5);
        check("frz_req", 16'(int_req), 16'd1);
        check("frz_sel", 16'(int_sel), 16'd1);
        check("frz_wake", 16'(wake), 16'd1);
        cen = 1'b1;
        tick(3);
        check("rel_req", 16'(int_req), 16'd0);
        check("rel_vec", vector, 16'hFFFE);
        check("rel_wake", 16'(wake), 16'd0);

        // ack with no request is ignored
        pulse_ack();
        check("ign_ack_req", 16'(int_req), 16'd0);
        check("ign_ack_vec", vector, 16'hFFFE);

        // Collision: new NMI edge detected on the same edge as the ack
        nmi_n = 1'b0;
        tick(4);
        check("col_first_sel", 16'(int_sel), 16'd3);
        nmi_n = 1'b1;
        tick(3);
        nmi_n = 1'b0;
        tick(2);
        pulse_ack();
        check("col_ack_req", 16'(int_req), 16'd0);
        tick(1);
        check("col_re_req", 16'(int_req), 16'd1);
        check("col_re_sel", 16'(int_sel), 16'd3);
        pulse_ack();
        check("col_ack2_req", 16'(int_req), 16'd0);
        tick(1);
        check("col_done_req", 16'(int_req), 16'd0);

        // Async reset mid-request
        nmi_n = 1'b1;
        irq_n = 1'b0;
        tick(3);
        check("pre_rst_req", 16'(int_req), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 16'(int_req), 16'd0);
        check("mid_rst_vec", vector, 16'hFFFE);
        tick(1);
        rst = 1'b0;
        irq_n = 1'b1;
        tick(3);
        nmi_n = 1'b0;
        tick(6);
        check("post_rst_unarmed", 16'(int_req), 16'd0);
        nmi_n = 1'b1;
        tick(3);
        nmi_arm = 1'b1;
        tick(1);
        nmi_arm = 1'b0;
        nmi_n = 1'b0;
        tick(4);
        check("rearm_req", 16'(int_req), 16'd1);
        check("rearm_sel", 16'(int_sel), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
